// File: rtl/q_updater.sv
// Q-table owner for one intersection: zero-fills the table after reset, then applies
// Q(s,a) += alpha*(R + gamma*maxQ(s') - Q(s,a)) per accepted start and serves a registered row read port.
module q_updater #(
    parameter int NUM_STATES = 16,
    parameter int STATE_W    = 4,
    parameter int ALPHA_SH   = 1,
    parameter int GAMMA_SH   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      learning,
    input  logic                      start,
    input  logic [STATE_W-1:0]        S,
    input  logic [1:0]                A,
    input  logic signed [31:0]        R,
    input  logic [STATE_W-1:0]        S_next,
    input  logic [STATE_W-1:0]        rd_state,
    output logic signed [31:0]        Q0,
    output logic signed [31:0]        Q1,
    output logic signed [31:0]        Q2,
    output logic signed [31:0]        Q3,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_NEXT,
        ST_MAXQ,
        ST_CALC,
        ST_WR
    } state_t;

    localparam logic signed [35:0] SAT_MAX = 36'sh0_7FFF_FFFF;
    localparam logic signed [35:0] SAT_MIN = 36'shF_8000_0000;

    function automatic logic signed [35:0] sext36(input logic signed [31:0] v);
        return {{4{v[31]}}, v};
    endfunction

    function automatic logic signed [31:0] sat32(input logic signed [35:0] v);
        if (v > SAT_MAX) begin
            return 32'sh7FFF_FFFF;
        end else if (v < SAT_MIN) begin
            return 32'sh8000_0000;
        end
        return v[31:0];
    endfunction

    function automatic logic signed [31:0] max4(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input logic signed [31:0] c,
        input logic signed [31:0] d
    );
        logic signed [31:0] m_ab;
        logic signed [31:0] m_cd;
        m_ab = (a > b) ? a : b;
        m_cd = (c > d) ? c : d;
        return (m_ab > m_cd) ? m_ab : m_cd;
    endfunction

    // 36-bit headroom keeps every intermediate exact; only the final result is clamped.
    function automatic logic signed [31:0] calc_qnew(
        input logic signed [31:0] qsa,
        input logic signed [31:0] maxq,
        input logic signed [31:0] rew
    );
        logic signed [35:0] target;
        logic signed [35:0] delta;
        logic signed [35:0] qnew;
        target = sext36(rew) + sext36(maxq) - (sext36(maxq) >>> GAMMA_SH);
        delta  = target - sext36(qsa);
        qnew   = sext36(qsa) + (delta >>> ALPHA_SH);
        return sat32(qnew);
    endfunction

    state_t                r_state;
    state_t                w_next_state;
    logic [STATE_W-1:0]    r_init_cnt;
    logic                  r_done;
    logic                  w_accept;
    logic                  w_init_last;

    logic [STATE_W-1:0]    r_s;
    logic [1:0]            r_a;
    logic signed [31:0]    r_r;
    logic [STATE_W-1:0]    r_sn;

    logic signed [31:0]    r_mem [NUM_STATES][4];
    logic [STATE_W-1:0]    w_rd_addr;
    logic signed [31:0]    r_rd_row_p1 [4];
    logic signed [31:0]    r_maxq_p2;
    logic signed [31:0]    r_qnew_p3;
    logic signed [31:0]    w_pg_row [4];
    logic signed [31:0]    r_q [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT:    if (w_init_last) w_next_state = ST_IDLE;
            ST_IDLE:    if (start && learning) w_next_state = ST_RD_NEXT;
            ST_RD_NEXT: w_next_state = ST_MAXQ;
            ST_MAXQ:    w_next_state = ST_CALC;
            ST_CALC:    w_next_state = ST_WR;
            ST_WR:      w_next_state = ST_IDLE;
            default:    w_next_state = ST_INIT;
        endcase
    end

    always_comb begin
        busy        = (r_state != ST_IDLE);
        w_accept    = (r_state == ST_IDLE) && start && learning;
        w_init_last = (r_state == ST_INIT) && (r_init_cnt == STATE_W'(NUM_STATES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
            r_done <= (r_state == ST_WR);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s  <= S;
            r_a  <= A;
            r_r  <= R;
            r_sn <= S_next;
        end
    end

    // Gated by rst so a reset landing on the WR edge leaves the table untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                for (int w = 0; w < 4; w++) begin
                    r_mem[r_init_cnt][w] <= '0;
                end
            end else if (r_state == ST_WR) begin
                r_mem[r_s][r_a] <= r_qnew_p3;
            end
        end
    end

    assign w_rd_addr = (r_state == ST_RD_NEXT) ? r_sn : r_s;

    // p1: row S_next (from RD_NEXT) then row S (from MAXQ)
    always_ff @(posedge clk) begin
        for (int w = 0; w < 4; w++) begin
            r_rd_row_p1[w] <= r_mem[w_rd_addr][w];
        end
    end

    // p2: maxQ(s') captured before row S overwrites the read register
    always_ff @(posedge clk) begin
        if (r_state == ST_MAXQ) begin
            r_maxq_p2 <= max4(r_rd_row_p1[0], r_rd_row_p1[1], r_rd_row_p1[2], r_rd_row_p1[3]);
        end
    end

    // p3: saturated Q(s,a) waiting for the WR edge
    always_ff @(posedge clk) begin
        if (r_state == ST_CALC) begin
            r_qnew_p3 <= calc_qnew(r_rd_row_p1[r_a], r_maxq_p2, r_r);
        end
    end

    always_comb begin
        for (int w = 0; w < 4; w++) begin
            w_pg_row[w] = r_mem[rd_state][w];
        end
        if ((r_state == ST_WR) && (rd_state == r_s)) begin
            w_pg_row[r_a] = r_qnew_p3;
        end
    end

    // The table contents are undefined until INIT finishes, so the read port is forced to zero.
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_INIT)) begin
            for (int w = 0; w < 4; w++) begin
                r_q[w] <= '0;
            end
        end else begin
            for (int w = 0; w < 4; w++) begin
                r_q[w] <= w_pg_row[w];
            end
        end
    end

    assign Q0   = r_q[0];
    assign Q1   = r_q[1];
    assign Q2   = r_q[2];
    assign Q3   = r_q[3];
    assign done = r_done;

endmodule

// File: doc/q_updater.md
Name: q_updater

Overview:
- Owns the Q-table for one intersection and performs the Q-learning update from the action chosen by the policy generator and the observed reward.
- Supplies the per-state Q-row (Q0..Q3) that the policy generator consumes.
- Instantiated once per intersection (A and B).
- Update rule: Q(s,a) <= Q(s,a) + alpha*(R + gamma*maxQ(s') - Q(s,a)), with shift-based alpha and gamma.

Parameters:
NUM_STATES, 16, number of Q-table rows (states)
STATE_W, 4, state index width, equal to clog2(NUM_STATES)
ALPHA_SH, 1, learning rate alpha = 2^-ALPHA_SH; legal range 0..31
GAMMA_SH, 3, discount gamma = 1 - 2^-GAMMA_SH; legal range 1..31

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
learning  in  1  update enable; start is ignored while low
start  in  1  one-cycle request to perform an update
S  in  STATE_W  current state s
A  in  2  action taken in s (from the policy generator)
R  in  32  reward, signed two's complement
S_next  in  STATE_W  resulting state s'
rd_state  in  STATE_W  row to present on Q0..Q3
Q0, Q1, Q2, Q3  out  32 each  signed Q-values of row rd_state
busy  out  1  high while initialising or updating
done  out  1  one-cycle pulse when the update write commits

Behaviour:
- Storage: NUM_STATES rows x 4 signed 32-bit words. One internal update read port, one PG read port, one write port.
- Reset (rst high at a clock edge):
  - FSM -> INIT, row counter -> 0.
  - Q0..Q3 = 0, done = 0, busy = 1.
  - Reset mid-update aborts the update; no partial write occurs.
- INIT: writes row counter's row to all-zero, one row per cycle. After row NUM_STATES-1 is written -> IDLE, busy = 0. INIT lasts exactly NUM_STATES cycles. start is ignored during INIT.
- IDLE:
  - start=1 and learning=1 at an edge: latch S, A, R, S_next; busy = 1; -> RD_NEXT.
  - Otherwise stay in IDLE.
  - start while busy is ignored; no queueing.
- RD_NEXT: issue read of row S_next -> MAXQ.
- MAXQ: register maxQ = signed max of the 4 words; issue read of row S -> CALC.
- CALC: compute Qnew and register it -> WR. Arithmetic:
  - Qsa = word A of row S.
  - Work in 36-bit signed with sign extension.
  - target = R + maxQ - (maxQ >>> GAMMA_SH).
  - delta = target - Qsa.
  - Qnew = Qsa + (delta >>> ALPHA_SH), arithmetic shifts.
  - Saturate Qnew to [32'h80000000, 32'h7FFFFFFF].
- WR: write Qnew into word A of row S; the other 3 words are unchanged.
  - The write commits at the edge leaving WR.
  - At that same edge: done = 1 for exactly one cycle, busy = 0, -> IDLE.
- Latency: if start is accepted at edge N, the write commits and done rises at edge N+4. Throughput is one update per 5 cycles (a new start is accepted at edge N+5 at the earliest).
- S == S_next is legal: maxQ uses the pre-update row.
- PG read port: Q0..Q3 are registered with a 1-cycle latency from rd_state.
  - Write-first bypass: if rd_state equals the row being written at that edge, Q0..Q3 show the post-write row.
  - Q0..Q3 read 0 throughout INIT.
- Dropping learning mid-update does not abort an update already in progress.

Test Plan:
- Reset, then 16 idle cycles -> busy high for exactly 16 cycles after rst drops; every rd_state reads Q0..Q3 = 0; done never pulses.
- Defaults. Update S=2, A=1, R=100, S_next=3 from a zeroed table -> done at accept+4; rd_state=2 gives Q1 = 50 and Q0, Q2, Q3 = 0.
- Then S=5, A=0, R=0, S_next=2 -> maxQ = 50, target = 50 - 6 = 44, so Q(5,0) = 22.
- Then S=2, A=1, R=-200, S_next=7 -> target = -200, delta = -250, so Q(2,1) = 50 - 125 = -75 (0xFFFFFFB5).
- Saturation, with ALPHA_SH=0:
  - S=0, A=0, R=32'h7FFFFFFF, S_next=1 -> Q(0,0) = 32'h7FFFFFFF.
  - Then S=1, A=0, R=32'h7FFFFFFF, S_next=0 -> Q(1,0) saturates to 32'h7FFFFFFF.
- Protocol:
  - start with learning=0 is ignored (no busy, no done).
  - start pulsed at accept+2 is ignored; only one done.
  - rst asserted at accept+3 -> no write; table re-zeroed; busy for 16 cycles.
  - rd_state=2 held during the WR edge of an S=2 update -> Q0..Q3 show the new value on the done cycle.
